time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Time-setting controller for the binary clock. It turns two raw push-buttons (mode, increment) into a set-time sequence: freeze the counters, edit hours, edit minutes, then load the edited time. The hours/minutes/seconds counter chain and the LED matrix driver sit downstream. It produces the counter enable, a one-cycle load strobe with load values, display source values and a blink mask for the field being edited.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples needed to accept a new button level.
- REPEAT_DELAY, 50: cycles inc must stay held (after its press event) before the first auto-repeat event.
- REPEAT_PERIOD, 10: cycles between later auto-repeat events while inc stays held.
- BLINK_HALF, 25: cycles per blink half-period.
- TIMEOUT, 1000: cycles with no button event in a set state before the edit is abandoned.
- clk  in  1  system clock (the centisecond tick clock); single clock domain.
- rst  in  1  reset; synchronous, active-high.
- btn_mode_raw  in  1  raw mode button, asynchronous, high = pressed.
- btn_inc_raw  in  1  raw increment button, asynchronous, high = pressed.
- cur_hours  in  5  live hours from the counter chain, 0..23.
- cur_minutes  in  6  live minutes, 0..59.
- run_en  out  1  counter chain enable; 0 freezes counting.
- load  out  1  one-cycle strobe; counters take load_* on this cycle.
- load_hours  out  5  hours to load.
- load_minutes  out  6  minutes to load.
- load_seconds  out  6  seconds to load; always 0.
- disp_hours  out  5  hours value for the display.
- disp_minutes  out  6  minutes value for the display.
- blank_mask  out  3  {hours, minutes, seconds} field blank request; 1 = blank.
- mode  out  2  0 RUN, 1 SET_H, 2 SET_M; value 3 is never produced.

## Operation
- Each button path:
  - 2-flop synchronizer.
  - Debouncer: the accepted level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it.
  - Press event: one-cycle pulse on the accepted 0→1 edge.
- Inc auto-repeat:
  - While accepted inc stays 1, an extra inc event fires REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles.
  - Releasing inc clears the repeat counter.
  - Auto-repeat runs only in SET_H and SET_M.
- FSM:
  - RUN: run_en=1, disp_* = cur_*, blank_mask=0. On a mode event: capture cur_hours/cur_minutes into the shadow registers, go to SET_H.
  - SET_H: run_en=0. An inc event increments shadow_h (23→0). A mode event goes to SET_M.
  - SET_M: run_en=0. An inc event increments shadow_m (59→0). A mode event pulses load with load_hours=shadow_h, load_minutes=shadow_m, load_seconds=0, and goes to RUN.
  - In SET_H and SET_M, disp_* = shadow values.
- Mode and inc events in the same cycle: the mode event wins and the inc event is dropped.
- Timeout: the idle counter resets on any event and on entering a set state. When it reaches TIMEOUT in SET_H or SET_M, go to RUN with no load; shadow values are discarded.
- Blink: a free-running phase bit toggles every BLINK_HALF cycles.
  - SET_H: blank_mask[2] = phase.
  - SET_M: blank_mask[1] = phase.
  - All other mask bits are 0.
  - The phase resets to 0 (visible) on every state entry and every inc event.
- Arithmetic: increments are modular compares against constants. No out-of-range value is ever held or output.
- The mode button is ignored while the load pulse is asserted.

## Timing
- Reset (synchronous): state RUN, run_en=1, load=0, load_*=0, shadow=0, blink phase 0, blank_mask=0, idle/repeat/debounce counters 0, accepted button levels 0.
- Registered outputs: run_en, load, load_*, mode, blank_mask.
- disp_* is combinational: a mux of cur_* or shadow selected by registered state.
- Latency: a raw edge held stable at cycle t gives an event pulse at t+2+DEBOUNCE_CYCLES. State and outputs update at the next edge, i.e. visible at t+3+DEBOUNCE_CYCLES.
- load is high for exactly one cycle, in the same cycle mode returns to 0. run_en returns to 1 in that same cycle.
- rst during SET_H/SET_M: next cycle is RUN with no load pulse.
- Button glitches shorter than DEBOUNCE_CYCLES samples produce no event.

## Structure
- Package time_set_pkg:
  - state enum {RUN, SET_H, SET_M}.
  - HOURS_MAX=23, MINUTES_MAX=59.
  - Field width constants 5/6/6.
- Sub-module button_debounce (synchronizer, debouncer, press pulse, optional auto-repeat enable), instantiated twice; repeat enabled only for inc.
- FSM, shadow registers, idle timer and blink generator live in time_set_ctrl.

## Test plan
- Reset, then idle 100 cycles → mode=0, run_en=1, load=0, blank_mask=0, disp_hours follows cur_hours=7.
- cur=13:45; mode press, 3 inc presses, mode, 2 inc, mode → one load pulse with 16:47, seconds 0. run_en=0 from the first accepted mode until the load cycle.
- Hours wrap: cur_hours=22, enter SET_H, 2 inc → shadow 0. Minutes wrap: cur_minutes=59, 1 inc in SET_M → 0.
- Bounce: a 3-cycle inc pulse, a 3-cycle low, then held high → exactly one increment (DEBOUNCE_CYCLES=4). Inc held for 50+3×10 cycles in SET_M → 1+1+3 = 5 increments.
- Mode and inc raw edges in the same cycle in SET_H → state SET_M, shadow_h unchanged. No events for 1000 cycles in SET_M → mode=0, no load, run_en=1.
- rst asserted mid-SET_M → next cycle mode=0, run_en=1, load=0. blank_mask toggles every 25 cycles in SET_H on bit 2 only.

Source files
------------

// File: rtl/time_set_pkg.sv
// Shared types and constants for the binary-clock time-setting controller.
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  localparam int HOURS_W   = 5;
  localparam int MINUTES_W = 6;
  localparam int SECONDS_W = 6;

  localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
  localparam logic [MINUTES_W-1:0] MINUTES_MAX = 6'd59;

  function automatic logic [HOURS_W-1:0] next_hours(input logic [HOURS_W-1:0] h);
    return (h >= HOURS_MAX) ? '0 : h + 5'd1;
  endfunction

  function automatic logic [MINUTES_W-1:0] next_minutes(input logic [MINUTES_W-1:0] m);
    return (m >= MINUTES_MAX) ? '0 : m + 6'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button to event pulses: 2-flop synchronizer, level debouncer,
// press pulse on the accepted rising edge and optional hold-to-repeat events.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic repeat_allow,
  output logic evt
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic            sync1, sync2;
  logic            level;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;
  logic             rpt_fire;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level  <= sync2;
          db_cnt <= '0;
          press  <= sync2;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // rpt_armed marks that the first (long) delay has already elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_fire  <= 1'b0;
    end else begin
      rpt_fire <= 1'b0;
      if (!REPEAT_EN || !level || !repeat_allow) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b0;
      end else if ((!rpt_armed && rpt_cnt == RPT_W'(REPEAT_DELAY - 1)) ||
                   ( rpt_armed && rpt_cnt == RPT_W'(REPEAT_PERIOD - 1))) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b1;
        rpt_fire  <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  assign evt = press | rpt_fire;

endmodule

// File: rtl/time_set_ctrl.sv
// Set-time controller: freezes the counter chain, edits hours then minutes
// in shadow registers, and loads the edited time with a one-cycle strobe.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10,
  parameter int BLINK_HALF      = 25,
  parameter int TIMEOUT         = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_raw,
  input  logic       btn_inc_raw,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [4:0] disp_hours,
  output logic [5:0] disp_minutes,
  output logic [2:0] blank_mask,
  output logic [1:0] mode
);
  import time_set_pkg::*;

  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);

  state_t                 state, state_nx;
  logic [HOURS_W-1:0]     shadow_h, shadow_h_nx;
  logic [MINUTES_W-1:0]   shadow_m, shadow_m_nx;
  logic [IDLE_W-1:0]      idle_cnt, idle_cnt_nx;
  logic [BLINK_W-1:0]     blink_cnt, blink_cnt_nx;
  logic                   phase, phase_nx;
  logic                   load_nx;
  logic [HOURS_W-1:0]     load_hours_nx;
  logic [MINUTES_W-1:0]   load_minutes_nx;
  logic                   mode_pulse, inc_pulse;
  logic                   mode_evt, inc_evt;
  logic                   entering;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
  ) u_mode_btn (
    .clk(clk), .rst(rst), .raw(btn_mode_raw), .repeat_allow(1'b0), .evt(mode_pulse)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
  ) u_inc_btn (
    .clk(clk), .rst(rst), .raw(btn_inc_raw), .repeat_allow(state != RUN), .evt(inc_pulse)
  );

  // Mode is masked during the load strobe and beats a simultaneous inc.
  assign mode_evt = mode_pulse & ~load;
  assign inc_evt  = inc_pulse & ~mode_evt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx        = state;
    shadow_h_nx     = shadow_h;
    shadow_m_nx     = shadow_m;
    load_nx         = 1'b0;
    load_hours_nx   = load_hours;
    load_minutes_nx = load_minutes;

    unique case (state)
      RUN: begin
        if (mode_evt) begin
          state_nx    = SET_H;
          shadow_h_nx = (cur_hours > HOURS_MAX) ? '0 : cur_hours;
          shadow_m_nx = (cur_minutes > MINUTES_MAX) ? '0 : cur_minutes;
        end
      end
      SET_H: begin
        if (mode_evt)                                 state_nx    = SET_M;
        else if (inc_evt)                             shadow_h_nx = next_hours(shadow_h);
        else if (idle_cnt == IDLE_W'(TIMEOUT - 1))    state_nx    = RUN;
      end
      SET_M: begin
        if (mode_evt) begin
          state_nx        = RUN;
          load_nx         = 1'b1;
          load_hours_nx   = shadow_h;
          load_minutes_nx = shadow_m;
        end else if (inc_evt) begin
          shadow_m_nx = next_minutes(shadow_m);
        end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase

    entering = (state_nx != state);

    if (entering || mode_evt || inc_evt || state_nx == RUN) idle_cnt_nx = '0;
    else                                                     idle_cnt_nx = idle_cnt + 1'b1;

    if (entering || inc_evt) begin
      blink_cnt_nx = '0;
      phase_nx     = 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt_nx = '0;
      phase_nx     = ~phase;
    end else begin
      blink_cnt_nx = blink_cnt + 1'b1;
      phase_nx     = phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      shadow_h     <= '0;
      shadow_m     <= '0;
      idle_cnt     <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
      run_en       <= 1'b1;
      load         <= 1'b0;
      load_hours   <= '0;
      load_minutes <= '0;
      blank_mask   <= '0;
      mode         <= RUN;
    end else begin
      state        <= state_nx;
      shadow_h     <= shadow_h_nx;
      shadow_m     <= shadow_m_nx;
      idle_cnt     <= idle_cnt_nx;
      blink_cnt    <= blink_cnt_nx;
      phase        <= phase_nx;
      run_en       <= (state_nx == RUN);
      load         <= load_nx;
      load_hours   <= load_hours_nx;
      load_minutes <= load_minutes_nx;
      blank_mask   <= {(state_nx == SET_H) & phase_nx, (state_nx == SET_M) & phase_nx, 1'b0};
      mode         <= state_nx;
    end
  end

  assign load_seconds = '0;
  assign disp_hours   = (state == RUN) ? cur_hours   : shadow_h;
  assign disp_minutes = (state == RUN) ? cur_minutes : shadow_m;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: expected loads go through a scoreboard
// queue; display, mode and blink behaviour are checked at fixed points.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode_raw = 1'b0;
  logic       btn_inc_raw = 1'b0;
  logic [4:0] cur_hours = 5'd7;
  logic [5:0] cur_minutes = 6'd0;
  logic       run_en, load;
  logic [4:0] load_hours, disp_hours;
  logic [5:0] load_minutes, load_seconds, disp_minutes;
  logic [2:0] blank_mask;
  logic [1:0] mode;

  typedef struct { int h; int m; int s; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int load_count = 0;
  int run_viol = 0;
  int load_viol = 0;

  time_set_ctrl dut (
    .clk(clk), .rst(rst), .btn_mode_raw(btn_mode_raw), .btn_inc_raw(btn_inc_raw),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .run_en(run_en), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .disp_hours(disp_hours), .disp_minutes(disp_minutes), .blank_mask(blank_mask),
    .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Scoreboard consumer plus run_en/load consistency monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (mode != 2'd0 && run_en) run_viol++;
      if (load && (mode != 2'd0 || !run_en)) load_viol++;
      if (load) begin
        load_count++;
        if (sb.size() == 0) begin
          check("load_unexpected", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("load_hours", load_hours, e.h);
          check("load_minutes", load_minutes, e.m);
          check("load_seconds", load_seconds, e.s);
        end
      end
    end
  end

  task automatic press(input bit m, input bit i, input int hold);
    btn_mode_raw = m;
    btn_inc_raw  = i;
    repeat (hold) @(negedge clk);
    btn_mode_raw = 1'b0;
    btn_inc_raw  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic expect_load(input int h, input int m);
    exp_t e;
    e.h = h; e.m = m; e.s = 0;
    sb.push_back(e);
  endtask

  initial begin
    int prev_b, last_change, changes, low_bad;
    exp_t dummy;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_mode", mode, 0);
    check("reset_run_en", run_en, 1);
    check("reset_load", load, 0);
    check("reset_load_hours", load_hours, 0);
    repeat (100) @(negedge clk);
    check("idle_mode", mode, 0);
    check("idle_run_en", run_en, 1);
    check("idle_blank", blank_mask, 0);
    check("idle_disp_hours", disp_hours, 7);

    // Full edit: 13:45 -> 16:47
    cur_hours = 5'd13; cur_minutes = 6'd45;
    press(1, 0, 8);
    check("seth_mode", mode, 1);
    check("seth_run_en", run_en, 0);
    check("seth_disp_h", disp_hours, 13);
    repeat (3) press(0, 1, 8);
    check("seth_inc3", disp_hours, 16);
    press(1, 0, 8);
    check("setm_mode", mode, 2);
    check("setm_disp_m", disp_minutes, 45);
    repeat (2) press(0, 1, 8);
    check("setm_inc2", disp_minutes, 47);
    expect_load(16, 47);
    press(1, 0, 8);
    check("after_load_mode", mode, 0);
    check("after_load_run_en", run_en, 1);
    check("load_count_1", load_count, 1);

    // Wraps
    cur_hours = 5'd22; cur_minutes = 6'd59;
    press(1, 0, 8);
    check("wrap_h_start", disp_hours, 22);
    repeat (2) press(0, 1, 8);
    check("wrap_h", disp_hours, 0);
    press(1, 0, 8);
    check("wrap_m_start", disp_minutes, 59);
    press(0, 1, 8);
    check("wrap_m", disp_minutes, 0);
    expect_load(0, 0);
    press(1, 0, 8);
    check("load_count_2", load_count, 2);

    // Bounce and auto-repeat in SET_M
    cur_hours = 5'd10; cur_minutes = 6'd20;
    press(1, 0, 8);
    press(1, 0, 8);
    check("bounce_setm", mode, 2);
    btn_inc_raw = 1'b1; repeat (3) @(negedge clk);
    btn_inc_raw = 1'b0; repeat (3) @(negedge clk);
    press(0, 1, 20);
    check("bounce_one_inc", disp_minutes, 21);
    press(0, 1, 85);
    check("repeat_five_inc", disp_minutes, 26);
    expect_load(10, 26);
    press(1, 0, 8);
    check("load_count_3", load_count, 3);

    // Simultaneous mode+inc in SET_H, then timeout in SET_M
    cur_hours = 5'd5; cur_minutes = 6'd30;
    press(1, 0, 8);
    press(1, 1, 8);
    check("simul_mode", mode, 2);
    check("simul_shadow_h", disp_hours, 5);
    repeat (900) @(negedge clk);
    check("pre_timeout_mode", mode, 2);
    repeat (120) @(negedge clk);
    check("timeout_mode", mode, 0);
    check("timeout_run_en", run_en, 1);
    check("timeout_no_load", load_count, 3);

    // Reset in SET_M
    press(1, 0, 8);
    press(1, 0, 8);
    check("rst_pre_mode", mode, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_run_en", run_en, 1);
    check("rst_load", load, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Blink in SET_H
    press(1, 0, 8);
    check("blink_state", mode, 1);
    prev_b = blank_mask[2];
    last_change = -1; changes = 0; low_bad = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (blank_mask[1:0] != 2'b00) low_bad++;
      if (int'(blank_mask[2]) != prev_b) begin
        if (last_change >= 0) check("blink_interval", i - last_change, 25);
        last_change = i;
        changes++;
      end
      prev_b = blank_mask[2];
    end
    check("blink_low_bits", low_bad, 0);
    check("blink_toggles", changes >= 4, 1);

    check("run_en_low_in_set", run_viol, 0);
    check("load_cycle_outputs", load_viol, 0);
    check("sb_empty", sb.size(), 0);
    check("load_total", load_count, 3);
    if (sb.size() != 0) dummy = sb.pop_front();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
